// File: rtl/throu_pkg.sv
// Shared definitions for the throu_unit pass-through datapath: op-field width and op encodings.
package throu_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_MOV  = 3'd0;
   localparam logic [OP_W-1:0] OP_CLR  = 3'd1;
   localparam logic [OP_W-1:0] OP_NSWP = 3'd2;
   localparam logic [OP_W-1:0] OP_HSWP = 3'd3;
   localparam logic [OP_W-1:0] OP_BREV = 3'd4;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd5;

endpackage

// File: rtl/throu_sfifo.sv
// Synchronous FIFO with occupancy counter; a push while full is refused even if a pop happens too.
module throu_sfifo #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] last_q;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // When empty, the output holds the most recently popped entry rather than stale storage.
   assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            last_q   <= mem_q[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/throu_unit.sv
// Registered data-movement unit with output FIFO.
// Optional out_err flag for reserved ops: define THROU_UNIT_OPERR_EN.
module throu_unit
   import throu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_oprd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef THROU_UNIT_OPERR_EN
   output logic             out_err,
`endif
   output logic             out_zero
);

   localparam int unsigned NB = WIDTH / 8;
`ifdef THROU_UNIT_OPERR_EN
   localparam int unsigned DW = WIDTH + 2;
`else
   localparam int unsigned DW = WIDTH + 1;
`endif

   function automatic logic [WIDTH-1:0] apply_op(input logic [OP_W-1:0] op,
                                                 input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      r = x;
      case (op)
         OP_CLR:  r = '0;
         OP_NSWP: for (int unsigned b = 0; b < NB; b++)
                     r[b*8 +: 8] = {x[b*8 +: 4], x[b*8+4 +: 4]};
         OP_HSWP: r = {x[WIDTH/2-1:0], x[WIDTH-1:WIDTH/2]};
         OP_BREV: for (int unsigned b = 0; b < NB; b++)
                     r[b*8 +: 8] = x[(NB-1-b)*8 +: 8];
         OP_NOT:  r = ~x;
         default: r = x;
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0] res;
   logic [DW-1:0]    wdata, rdata;
   logic             full, empty;

   assign res = apply_op(in_op, in_oprd);
`ifdef THROU_UNIT_OPERR_EN
   assign wdata   = {in_op[2] & in_op[1], (res == '0), res};
   assign out_err = rdata[WIDTH+1];
`else
   assign wdata   = {(res == '0), res};
`endif

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_data  = rdata[WIDTH-1:0];
   assign out_zero  = rdata[WIDTH];

   throu_sfifo #(
      .WIDTH(DW),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (in_valid && in_ready),
      .pop_i   (out_valid && out_ready),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty)
   );

endmodule

// File: tb/tb_throu_unit.sv
// Directed self-checking bench for throu_unit (WIDTH=16, DEPTH=2); inputs and sampling on negedge.
module tb_throu_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [15:0] in_oprd;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_zero;
`ifdef THROU_UNIT_OPERR_EN
   logic        out_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   throu_unit #(
      .WIDTH(16),
      .DEPTH(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_oprd   (in_oprd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef THROU_UNIT_OPERR_EN
      .out_err   (out_err),
`endif
      .out_zero  (out_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] d);
      in_valid = v;
      in_op    = op;
      in_oprd  = d;
   endtask

   int          sent, rcvd, cnt;
   logic        push, pop;
   logic [15:0] exp_seq [5];
   logic [4:0]  exp_zero;

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 3'd0, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 16'h0000);
      chk("rst_out_zero", out_zero, 0);
      chk("rst_in_ready", in_ready, 1);

      drive(1'b1, 3'd0, 16'h12AB);
      @(negedge clk);
      chk("mov_valid", out_valid, 1);
      chk("mov_data", out_data, 16'h12AB);
      chk("mov_zero", out_zero, 0);

      // Streaming ops: each cycle pops the head and pushes the next result.
      exp_seq = '{16'h21BA, 16'hAB12, 16'hAB12, 16'hED54, 16'h0000};
      exp_zero = 5'b10000;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(1'b1, 3'd2, 16'h12AB);
            1: drive(1'b1, 3'd3, 16'h12AB);
            2: drive(1'b1, 3'd4, 16'h12AB);
            3: drive(1'b1, 3'd5, 16'h12AB);
            default: drive(1'b1, 3'd1, 16'hFFFF);
         endcase
         @(negedge clk);
         chk($sformatf("stream_valid%0d", i), out_valid, 1);
         chk($sformatf("stream_data%0d", i), out_data, exp_seq[i]);
         chk($sformatf("stream_zero%0d", i), out_zero, exp_zero[i]);
      end
      drive(1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      chk("drain_valid", out_valid, 0);
      chk("drain_hold_data", out_data, 16'h0000);

      // Backpressure with DEPTH=2.
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 16'h0001);
      @(negedge clk);
      chk("bp_ready1", in_ready, 1);
      drive(1'b1, 3'd0, 16'h0002);
      @(negedge clk);
      chk("bp_full_ready", in_ready, 0);
      chk("bp_head", out_data, 16'h0001);
      drive(1'b1, 3'd0, 16'h0003);
      @(negedge clk);
      chk("bp_held_ready", in_ready, 0);
      chk("bp_held_head", out_data, 16'h0001);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_pop_ready", in_ready, 1);
      chk("bp_head2", out_data, 16'h0002);
      @(negedge clk);
      drive(1'b0, 3'd0, 16'h0000);
      chk("bp_head3", out_data, 16'h0003);
      chk("bp_valid3", out_valid, 1);
      @(negedge clk);
      chk("bp_empty", out_valid, 0);

      // Pointer wrap: 10 pushes, out_ready toggling, checked against an occupancy model.
      sent = 0; rcvd = 0; cnt = 0;
      for (int cyc = 0; cyc < 80 && rcvd < 10; cyc++) begin
         chk("wrap_in_ready", in_ready, (cnt < 2) ? 1 : 0);
         chk("wrap_out_valid", out_valid, (cnt != 0) ? 1 : 0);
         drive(sent < 10, 3'd0, 16'hA000 + 16'(sent));
         out_ready = cyc[0];
         push = in_valid && (cnt < 2);
         pop  = out_ready && (cnt > 0);
         if (pop) begin
            chk($sformatf("wrap_data%0d", rcvd), out_data, 16'hA000 + 16'(rcvd));
            rcvd++;
         end
         if (push) sent++;
         cnt = cnt + (push ? 1 : 0) - (pop ? 1 : 0);
         @(negedge clk);
      end
      chk("wrap_rcvd", rcvd, 10);
      drive(1'b0, 3'd0, 16'h0000);
      out_ready = 1'b1;
      @(negedge clk);

      // Async reset with two queued entries.
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 16'h1111);
      @(negedge clk);
      drive(1'b1, 3'd0, 16'h2222);
      @(negedge clk);
      drive(1'b0, 3'd0, 16'h0000);
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_data", out_data, 16'h1111);
      chk("pre_rst_ready", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 16'h0000);
      chk("arst_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_data", out_data, 16'h0000);
      @(negedge clk);
      chk("post_rst_valid2", out_valid, 0);

      // Reserved ops behave as MOV.
      drive(1'b1, 3'd7, 16'h5A5A);
      @(negedge clk);
      chk("rsv_data", out_data, 16'h5A5A);
      chk("rsv_zero", out_zero, 0);
`ifdef THROU_UNIT_OPERR_EN
      chk("rsv_err", out_err, 1);
`endif
      drive(1'b1, 3'd0, 16'h0000);
      @(negedge clk);
      chk("mov0_data", out_data, 16'h0000);
      chk("mov0_zero", out_zero, 1);
      chk("mov0_valid", out_valid, 1);
`ifdef THROU_UNIT_OPERR_EN
      chk("mov0_err", out_err, 0);
`endif
      drive(1'b1, 3'd6, 16'hC3C3);
      @(negedge clk);
      chk("rsv6_data", out_data, 16'hC3C3);
`ifdef THROU_UNIT_OPERR_EN
      chk("rsv6_err", out_err, 1);
`endif
      drive(1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      chk("end_empty", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
